// File: rtl/rr_mux_4x1_stream.sv
// Four-channel round-robin stream merger with a registered, source-tagged output.
// Define RR_MUX_GRANT_CNT_EN to add saturating per-channel grant counters.
module rr_mux_4x1_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    output logic [4*16-1:0]    grant_cnt
`endif
);

    logic [1:0]       r_last;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;

    logic             w_load;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt;
    logic             w_xfer;
    logic [1:0]       w_idx;

    assign w_load = rst_n & (~r_out_valid | out_ready);

    // Scan from the channel after the last winner, wrapping back to it.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        w_idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_gnt_vld && in_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    assign w_xfer = w_gnt_vld & w_load;

    always_comb begin
        in_ready = 4'b0000;
        if (w_xfer) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= 2'd3;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
        end else if (w_xfer) begin
            r_last      <= w_gnt;
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_gnt*WIDTH +: WIDTH];
            r_out_sel   <= w_gnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

`ifdef RR_MUX_GRANT_CNT_EN
    logic [15:0] r_cnt [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt[k] <= 16'd0;
            end else if (w_xfer && w_gnt == 2'(k)
                         && r_cnt[k] != 16'hFFFF) begin
                r_cnt[k] <= r_cnt[k] + 16'd1;
            end
        end
        assign grant_cnt[k*16 +: 16] = r_cnt[k];
    end
`endif

endmodule

// File: tb/tb_rr_mux_4x1_stream.sv
// Directed self-checking bench for rr_mux_4x1_stream.
// Counter checks run only when RR_MUX_GRANT_CNT_EN is defined.
module tb_rr_mux_4x1_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
`ifdef RR_MUX_GRANT_CNT_EN
    logic [63:0]    grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_mux_4x1_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef RR_MUX_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h",
                     tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] d);
        in_data[k*W +: W] = d;
    endtask

    task automatic chk_out(input string tag,
                           input logic v,
                           input logic [1:0] s,
                           input logic [7:0] d);
        chk({tag, ".v"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"}, 32'(out_sel), 32'(s));
        chk({tag, ".data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 8'hA0 + 8'(k));

        // Reset with all channels requesting.
        repeat (3) tick();
        chk("rst.rdy", 32'(in_ready), 32'h0);
        chk_out("rst", 1'b0, 2'd0, 8'h00);

        // Round-robin, all valid.
        rst_n = 1'b1;
        #1;
        chk("rr.rdy0", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1,
                    2'(i % 4), 8'hA0 + 8'(i % 4));
            chk($sformatf("rr%0d.rdy", i), 32'(in_ready),
                32'(4'b0001 << ((i + 1) % 4)));
        end

        // Sparse: channels 1 and 3 only.
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1010;
        #1;
        chk("sp.rdy0", 32'(in_ready), 32'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("sp%0d", i), 1'b1,
                    (i % 2 == 0) ? 2'd1 : 2'd3,
                    (i % 2 == 0) ? 8'hA1 : 8'hA3);
            chk($sformatf("sp%0d.rdy", i), 32'(in_ready),
                (i % 2 == 0) ? 32'h8 : 32'h2);
        end

        // Backpressure holding a word from channel 2.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        set_ch(2, 8'h55);
        tick();
        chk_out("bp.load", 1'b1, 2'd2, 8'h55);
        in_valid = 4'b0101;
        set_ch(0, 8'h11);
        set_ch(2, 8'h66);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp%0d", i), 1'b1, 2'd2, 8'h55);
            chk($sformatf("bp%0d.rdy", i), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rel.rdy", 32'(in_ready), 32'h1);
        tick();
        chk_out("bp.b2b", 1'b1, 2'd0, 8'h11);

        // Reset while a word is held under backpressure.
        out_ready = 1'b0;
        in_valid  = 4'b1001;
        set_ch(0, 8'h77);
        set_ch(3, 8'h33);
        #1;
        chk("mr.pre.rdy", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mr.rst.rdy", 32'(in_ready), 32'h0);
        tick();
        chk_out("mr.rst", 1'b0, 2'd0, 8'h00);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr.rel.rdy", 32'(in_ready), 32'h1);
        tick();
        chk_out("mr.win", 1'b1, 2'd0, 8'h77);

        // Consume with nothing new: valid drops, data stays stale.
        in_valid = 4'b0000;
        tick();
        chk_out("drain", 1'b0, 2'd0, 8'h77);
        chk("drain.rdy", 32'(in_ready), 32'h0);

`ifdef RR_MUX_GRANT_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt.rst", grant_cnt[31:0], 32'h0);
        in_valid = 4'b0010;
        repeat (10) tick();
        in_valid = 4'b0000;
        tick();
        chk("cnt.c1", 32'(grant_cnt[31:16]), 32'd10);
        chk("cnt.c0", 32'(grant_cnt[15:0]), 32'd0);
        chk("cnt.c2", 32'(grant_cnt[47:32]), 32'd0);
        chk("cnt.c3", 32'(grant_cnt[63:48]), 32'd0);
        in_valid = 4'b0001;
        repeat (65540) tick();
        in_valid = 4'b0000;
        tick();
        chk("cnt.sat", 32'(grant_cnt[15:0]), 32'hFFFF);
        chk("cnt.c1k", 32'(grant_cnt[31:16]), 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
